// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: state encoding and request word layout shared by the SPI stream arbiter
package spi_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_STOP, S_WAIT_DONE, S_GAP} state_e;
  localparam int WORD_W = 40;
  localparam int CMD_MSB = 39;
  localparam int CMD_LSB = 32;
  localparam int SECTOR_MSB = 31;
  localparam int SECTOR_LSB = 16;
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;
  localparam logic [7:0] STOP_CMD = 8'hFF;
  typedef struct packed {
    logic [CMD_MSB-CMD_LSB:0] cmd;
    logic [SECTOR_MSB-SECTOR_LSB:0] sector;
    logic [LEN_MSB-LEN_LSB:0] len;
  } req_word_t;
  localparam req_word_t STOP_WORD = '{cmd: STOP_CMD, sector: '0, len: '0};
endpackage

// File: rtl/spi_stream_arbiter_rr.sv
// rr_arbiter3: three-way round-robin pick, priority starting one above the last grant
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt,
  output logic       any
);
  logic [1:0] start, off;
  logic [2:0] rot, sum, idx;
  always_comb begin
    start = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    rot = 3'({req, req} >> start);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : 2'd2;
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= 3'd3) ? sum - 3'd3 : sum;
    any = |req;
    gnt = any ? (3'b001 << idx) : 3'b000;
  end
endmodule

// File: rtl/spi_stream_arbiter.sv
// spi_stream_arbiter: shares one SPI streamer among three requesters, with abort and watchdog stop
module spi_stream_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [WORD_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_abort,
  output logic [N_REQ-1:0]          grant,
  output logic [7:0]                s_dout,
  output logic [N_REQ-1:0]          s_valid,
  input  logic [N_REQ-1:0]          s_ready,
  output logic [WORD_W-1:0]         str_word,
  output logic                      str_valid,
  input  logic                      str_ready,
  input  logic [7:0]                str_din,
  input  logic                      str_ivalid,
  output logic                      str_oready,
  input  logic                      str_done,
  output logic [31:0]               xfer_count,
  output logic                      err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  state_e state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, ready_q, ready_d, req_eff, pick;
  req_word_t word_q, word_d, word_sel;
  logic [1:0] ptr_q, ptr_d, last_idx, pick_idx;
  logic [31:0] cnt_q, cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic pick_any, fwd, beat, own_abort, timeout;

  rr_arbiter3 u_rr (.req(req_eff), .last(last_idx), .gnt(pick), .any(pick_any));

  // A requester whose accept pulse is on the wire this cycle still shows req_valid; skip it.
  always_comb begin
    req_eff = req_valid & ~ready_q;
    last_idx = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    pick_idx = pick[1] ? 2'd1 : pick[2] ? 2'd2 : 2'd0;
    word_sel = req_word_t'(req_data[WORD_W*pick_idx +: WORD_W]);
    fwd = (state_q == S_STREAM) || (state_q == S_WAIT_DONE);
    beat = fwd & str_ivalid & |(s_ready & grant_q);
    own_abort = |(req_abort & grant_q);
    timeout = fwd & ~beat & (wd_q == WD_W'(TIMEOUT_CYC - 1));
    err = timeout & ~str_done;
    grant = grant_q;
    req_ready = ready_q;
    xfer_count = cnt_q;
    s_dout = str_din;
    s_valid = (fwd & str_ivalid) ? grant_q : '0;
    str_oready = beat;
    str_valid = (state_q == S_ISSUE) || (state_q == S_STOP);
    str_word = (state_q == S_ISSUE) ? word_q : (state_q == S_STOP) ? STOP_WORD : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ready_d = '0;
    word_d = word_q;
    ptr_d = ptr_q;
    cnt_d = (beat && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    wd_d = (fwd && !beat) ? wd_q + WD_W'(1) : '0;
    case (state_q)
      S_IDLE: if (pick_any) begin
        ready_d = pick;
        ptr_d = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
        if (word_sel.cmd != STOP_CMD) begin
          grant_d = pick;
          word_d = word_sel;
          cnt_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:     state_d = str_ready ? S_STREAM : S_ISSUE;
      S_STREAM:    state_d = str_done ? S_GAP : (own_abort || timeout) ? S_STOP : S_STREAM;
      S_STOP:      state_d = S_WAIT_DONE;
      S_WAIT_DONE: state_d = (str_done || timeout) ? S_GAP : S_WAIT_DONE;
      S_GAP:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (state_d == S_GAP) grant_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      word_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_spi_stream_arbiter.sv
// tb_spi_stream_arbiter: random requests and byte streams against a queue-level arbitration model
module tb_spi_stream_arbiter;
  localparam logic [39:0] STOPW = 40'hFF00000000;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid, req_abort, s_ready;
  logic [119:0] req_data;
  logic str_ready, str_ivalid, str_done;
  logic [7:0] str_din;
  logic [2:0] req_ready, grant, s_valid, t_req_ready, t_grant, t_s_valid;
  logic [7:0] s_dout, t_s_dout;
  logic [39:0] str_word, t_str_word;
  logic str_valid, str_oready, err, t_str_valid, t_str_oready, t_err;
  logic [31:0] xfer_count, t_xfer_count;
  int n_chk = 0, n_pass = 0, rr_next = 0;
  logic [39:0] words [3];
  logic [2:0] pend;
  int who;

  spi_stream_arbiter #(.N_REQ(3), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .req_abort(req_abort), .grant(grant), .s_dout(s_dout), .s_valid(s_valid), .s_ready(s_ready),
    .str_word(str_word), .str_valid(str_valid), .str_ready(str_ready), .str_din(str_din),
    .str_ivalid(str_ivalid), .str_oready(str_oready), .str_done(str_done),
    .xfer_count(xfer_count), .err(err));

  spi_stream_arbiter #(.N_REQ(3), .TIMEOUT_CYC(16)) dut_t (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(t_req_ready),
    .req_abort(req_abort), .grant(t_grant), .s_dout(t_s_dout), .s_valid(t_s_valid), .s_ready(s_ready),
    .str_word(t_str_word), .str_valid(t_str_valid), .str_ready(str_ready), .str_din(str_din),
    .str_ivalid(str_ivalid), .str_oready(t_str_oready), .str_done(str_done),
    .xfer_count(t_xfer_count), .err(t_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_pick(input logic [2:0] p);
    for (int k = 0; k < 3; k++) if (p[(rr_next + k) % 3]) return (rr_next + k) % 3;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rr_next = 0;
  endtask

  task automatic serve(input int w_i);
    logic [39:0] w;
    bit ff;
    int g, d;
    w = words[w_i];
    ff = (w[39:32] == 8'hFF);
    g = 0;
    do begin @(negedge clk); #1; g++; end while (req_ready == 3'b000 && g < 10);
    chk("req_ready", req_ready, 3'b001 << w_i);
    chk("grant", grant, ff ? 3'b000 : (3'b001 << w_i));
    req_valid[w_i] = 1'b0;
    rr_next = (w_i + 1) % 3;
    if (!ff) begin
      chk("issue_valid", str_valid, 1);
      chk("issue_word", str_word, w);
      d = $urandom_range(0, 2);
      repeat (d) begin
        str_ready = 1'b0;
        @(negedge clk); #1;
        chk("issue_hold", str_valid, 1);
      end
      str_ready = 1'b1;
      @(negedge clk);
      str_ready = 1'b0;
      #1;
      chk("stream_entry", str_valid, 0);
    end
  endtask

  task automatic stream(input int n, input int o, input int base);
    int sent, guard;
    bit adv, exp_or;
    sent = 0; guard = 0; adv = 1'b0;
    while (sent < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (adv) str_din = 8'($urandom);
      str_ivalid = ($urandom_range(0, 3) != 0);
      s_ready = 3'($urandom);
      if ($urandom_range(0, 3) != 0) s_ready[o] = 1'b1;
      #1;
      exp_or = str_ivalid & s_ready[o];
      chk("s_valid", s_valid, str_ivalid ? (3'b001 << o) : 3'b000);
      chk("str_oready", str_oready, exp_or);
      chk("xfer_count", xfer_count, base + sent);
      adv = exp_or;
      if (exp_or) begin
        chk("s_dout", s_dout, str_din);
        sent++;
      end
    end
    chk("stream_bytes", sent, n);
    @(negedge clk);
    str_ivalid = 1'b0;
    #1;
    chk("xfer_total", xfer_count, base + n);
  endtask

  task automatic finish_xfer();
    str_done = 1'b1;
    @(negedge clk);
    str_done = 1'b0;
    #1;
    chk("gap_grant", grant, 0);
    @(negedge clk); #1;
    chk("idle_grant", grant, 0);
    chk("idle_str_valid", str_valid, 0);
  endtask

  initial begin
    req_valid = 0; req_data = 0; req_abort = 0; s_ready = 0;
    str_ready = 0; str_din = 0; str_ivalid = 0; str_done = 0;
    do_reset();
    #1;
    chk("rst_grant", grant, 0); chk("rst_req_ready", req_ready, 0);
    chk("rst_str_valid", str_valid, 0); chk("rst_str_word", str_word, 0);
    chk("rst_s_valid", s_valid, 0); chk("rst_str_oready", str_oready, 0);
    chk("rst_err", err, 0); chk("rst_xfer", xfer_count, 0);
    // Round-robin rounds: first round all three at once, later random subsets incl. stop-cmd words.
    for (int r = 0; r < 6; r++) begin
      pend = (r == 0) ? 3'b111 : 3'($urandom_range(1, 7));
      for (int i = 0; i < 3; i++) begin
        words[i] = {8'($urandom_range(0, 254)), 32'($urandom)};
        if (r > 0 && $urandom_range(0, 4) == 0) words[i][39:32] = 8'hFF;
      end
      req_data = {words[2], words[1], words[0]};
      req_valid = pend;
      for (int k = 0; k < 3 && pend != 0; k++) begin
        who = model_pick(pend);
        serve(who);
        pend[who] = 1'b0;
        if (words[who][39:32] != 8'hFF) begin
          stream($urandom_range(1, 12), who, 0);
          finish_xfer();
        end
      end
    end
    words[1] = {8'h12, 16'h0040, 16'h0000};
    req_data = {words[2], words[1], words[0]};
    req_valid = 3'b010;
    serve(1);
    stream(514, 1, 0);
    finish_xfer();
    chk("xfer_514", xfer_count, 514);
    words[2] = {8'h21, 32'($urandom)};
    req_data = {words[2], words[1], words[0]};
    req_valid = 3'b100;
    serve(2);
    stream(20, 2, 0);
    str_din = 8'hA5;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      str_ivalid = 1'b1;
      s_ready = 3'($urandom) & 3'b011;
      #1;
      chk("stall_oready", str_oready, 0);
      chk("stall_count", xfer_count, 20);
      chk("stall_s_valid", s_valid, 3'b100);
    end
    stream(30, 2, 20);
    finish_xfer();
    words[0] = {8'h30, 32'($urandom)};
    req_data = {words[2], words[1], words[0]};
    req_valid = 3'b001;
    serve(0);
    stream(100, 0, 0);
    req_abort = 3'b100;
    @(negedge clk);
    req_abort = 3'b001;
    #1;
    chk("nonowner_abort", str_valid, 0);
    @(negedge clk);
    req_abort = 3'b000;
    #1;
    chk("stop_valid", str_valid, 1);
    chk("stop_word", str_word, STOPW);
    @(negedge clk); #1;
    chk("stop_once", str_valid, 0);
    stream(5, 0, 100);
    finish_xfer();
    chk("abort_count", xfer_count, 105);
    do_reset();
    words[2] = {8'h44, 32'($urandom)};
    req_data = {words[2], words[1], words[0]};
    req_valid = 3'b100;
    serve(2);
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) begin @(negedge clk); #1; end
      chk("to_err_stream", t_err, n == 16);
    end
    @(negedge clk); #1;
    chk("to_stop_valid", t_str_valid, 1);
    chk("to_stop_word", t_str_word, STOPW);
    chk("to_stop_err", t_err, 0);
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk); #1;
      chk("to_err_wait", t_err, m == 16);
      if (m == 1) chk("to_stop_once", t_str_valid, 0);
    end
    @(negedge clk); #1;
    chk("to_gap_grant", t_grant, 0); chk("to_gap_err", t_err, 0);
    chk("to_xfer", t_xfer_count, 0); chk("to_s_valid", t_s_valid, 0);
    chk("to_oready", t_str_oready, 0); chk("to_req_ready", t_req_ready, 0);
    chk("to_s_dout", t_s_dout, str_din);
    do_reset();
    for (int i = 0; i < 3; i++) words[i] = {8'(8'h50 + i), 32'($urandom)};
    req_data = {words[2], words[1], words[0]};
    req_valid = 3'b001;
    serve(0);
    stream(10, 0, 0);
    req_valid = 3'b011;
    str_ivalid = 1'b1;
    s_ready = 3'b111;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_next = 0;
    #1;
    chk("mid_rst_grant", grant, 0); chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_str_valid", str_valid, 0); chk("mid_rst_str_word", str_word, 0);
    chk("mid_rst_s_valid", s_valid, 0); chk("mid_rst_oready", str_oready, 0);
    chk("mid_rst_err", err, 0); chk("mid_rst_xfer", xfer_count, 0);
    str_ivalid = 1'b0;
    pend = 3'b011;
    while (pend != 0) begin
      who = model_pick(pend);
      serve(who);
      pend[who] = 1'b0;
      stream(3, who, 0);
      finish_xfer();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_stream_arbiter.md
SPI_STREAM_ARBITER -- requirements
Module: spi_stream_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (fixed 3 in this revision).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, watchdog limit in clk cycles.
REQ-003 SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  3  per-requester stream request pending.
REQ-007 req_data  in  120  three 40-bit words {cmd[39:32], sector[31:16], len[15:0]}; requester i occupies bits [40i+39:40i].
REQ-008 req_ready  out  3  one-cycle accept pulse per requester.
REQ-009 req_abort  in  3  per-requester abort level.
REQ-010 grant  out  3  one-hot current owner, or 0.
REQ-011 s_dout  out  8  byte to requesters, broadcast to all.
REQ-012 s_valid  out  3  byte valid, owner bit only.
REQ-013 s_ready  in  3  requester byte accept.
REQ-014 str_word  out  40  request word to streamer.
REQ-015 str_valid  out  1  streamer request valid.
REQ-016 str_ready  in  1  streamer request accept.
REQ-017 str_din  in  8  streamer byte.
REQ-018 str_ivalid  in  1  streamer byte valid.
REQ-019 str_oready  out  1  byte accepted, back to streamer.
REQ-020 str_done  in  1  streamer end-of-transfer pulse (its orst).
REQ-021 xfer_count  out  32  bytes delivered to current/last owner.
REQ-022 err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, STREAM, STOP, WAIT_DONE, GAP.
REQ-024 IDLE: if any req_valid, pick via round-robin starting one above last grant (lowest index after reset), latch its word, pulse its req_ready, set grant, clear xfer_count, go ISSUE in the same cycle transition.
REQ-025 IDLE: if the picked word has cmd==8'hFF, SHALL pulse req_ready, discard the word, leave grant 0, stay IDLE, and advance the round-robin pointer.
REQ-026 ISSUE: drive str_word=latched word, str_valid=1 until str_ready; on str_ready go STREAM and clear watchdog.
REQ-027 STREAM: s_dout=str_din, s_valid[owner]=str_ivalid, str_oready=str_ivalid & s_ready[owner] (combinational pass-through, zero latency).
REQ-028 Each str_ivalid & s_ready[owner] cycle SHALL increment xfer_count (saturate at 2^32-1) and clear watchdog.
REQ-029 STREAM: str_done SHALL go GAP; req_abort[owner] SHALL go STOP; watchdog reaching TIMEOUT_CYC SHALL pulse err and go STOP.
REQ-030 str_done has priority over abort and timeout in the same cycle.
REQ-031 STOP: drive str_word={8'hFF,32'h0}, str_valid=1 for exactly one cycle regardless of str_ready, then go WAIT_DONE, clearing watchdog.
REQ-032 WAIT_DONE: bytes still forwarded as in STREAM; str_done SHALL go GAP; watchdog expiry SHALL pulse err and go GAP.
REQ-033 GAP: one cycle, grant=0, then IDLE; guarantees streamer reset settles before the next request.
REQ-034 req_abort of a non-owner SHALL be ignored; a non-granted requester withdraws by dropping req_valid.
REQ-035 Outside STREAM/WAIT_DONE: s_valid=0, str_oready=0.
REQ-036 Watchdog SHALL be a counter of ceil(log2(TIMEOUT_CYC+1)) bits, counting only in STREAM and WAIT_DONE.

Reset
REQ-037 rst SHALL force IDLE, grant=0, req_ready=0, str_valid=0, str_word=0, s_valid=0, str_oready=0, err=0, xfer_count=0, round-robin pointer to 0, watchdog to 0.
REQ-038 rst mid-transfer SHALL abandon the transfer without issuing the stop word; the streamer is reset externally.

Structure
REQ-039 Package spi_arb_pkg SHALL hold the state encoding, STOP_CMD=8'hFF, and word field positions (CMD_MSB 39, SECTOR 31:16, LEN 15:0).
REQ-040 Round-robin selection SHALL be sub-module rr_arbiter3 (req[2:0], last[1:0] -> one-hot gnt, any).

Verification
REQ-041 All three request in the same cycle -> grants 0, 1, 2 in order, each str_word matching its requester's word; order wraps to 0 afterwards.
REQ-042 Requester 1 sends {8'h12,16'h0040,16'h0000}; streamer emits 514 bytes then str_done -> s_valid only on bit 1, xfer_count=514, GAP then IDLE.
REQ-043 req_abort[0] raised after 100 bytes -> exactly one cycle of str_word=40'hFF00000000; after str_done, grant=0.
REQ-044 s_ready held 0 for 50 cycles mid-stream -> str_oready=0, xfer_count frozen, no byte lost.
REQ-045 TIMEOUT_CYC=16, no bytes after str_ready -> err pulse at cycle 16 and stop word; with no str_done, second err at 16 cycles, then GAP.
REQ-046 rst asserted in STREAM -> next cycle all outputs at reset values; pending request is then granted to requester 0 first.
